extmem_req_bridge: RTL

// - Bridges the inverted_residual_block external-memory port to a word-addressed backing memory.
// - Port signals: request_extmem/write_extmem/addr_extmem/w_data in; valid_extmem/data_extmem out.
// - Buffers requests so the accelerator never stalls, and issues them in order.
// - Returns read data in order; counts traffic for debug.

---
 rtl/extmem_req_bridge.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/extmem_req_bridge.sv
// Request bridge from the accelerator external-memory port to a word-addressed memory:
// in-order request FIFO, bounded outstanding reads, in-order returns. Optional macro: REGION_CHECK_EN.
module extmem_req_bridge #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REQ_DEPTH  = 8,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned OFFSET_FMO = 4*(2**20),
  parameter int unsigned OFFSET_KEX = 6*(2**20),
  parameter int unsigned MEM_TOP    = 64*(2**20)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_extmem,
  input  logic              write_extmem,
  input  logic [ADDR_W-1:0] addr_extmem,
  input  logic [DATA_W-1:0] w_data,
  output logic              valid_extmem,
  output logic [DATA_W-1:0] data_extmem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              idle,
  output logic              ovf_err,
  output logic              region_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam int unsigned PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

  logic              fifo_we    [REQ_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [REQ_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [REQ_DEPTH];

  logic [PTR_W-1:0] head_ptr_reg, tail_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [OUT_W-1:0] outst_reg, outst_next;
  logic             idle_reg, ovf_err_reg, valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [31:0]      rd_cnt_reg, wr_cnt_reg;

  logic              fifo_empty, fifo_full;
  logic              head_we, head_kill;
  logic [ADDR_W-1:0] head_addr;
  logic              read_blocked, pop, push_ok;
  logic              issue_rd, issue_wr, ret;
  logic              ret_zero;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(REQ_DEPTH));
  assign head_we    = fifo_we[head_ptr_reg];
  assign head_addr  = fifo_addr[head_ptr_reg];

  // A read at the head waits while the outstanding window is full; writes never wait on it.
  assign read_blocked = !head_we && (outst_reg == OUT_W'(MAX_OUTST));
  assign mem_req      = !fifo_empty && !read_blocked && !(head_kill && head_we);
  assign pop          = (mem_req && mem_gnt) || (!fifo_empty && head_kill && head_we);
  assign push_ok      = request_extmem && (!fifo_full || pop);
  assign issue_rd     = mem_req && mem_gnt && !head_we;
  assign issue_wr     = mem_req && mem_gnt && head_we;
  assign ret          = mem_rvalid && (outst_reg != '0);

  assign mem_we    = head_we;
  assign mem_addr  = head_kill ? '0 : head_addr;
  assign mem_wdata = fifo_wdata[head_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (!push_ok && pop)
      count_next = count_reg - CNT_W'(1);
  end

  always_comb begin
    outst_next = outst_reg;
    if (issue_rd && !ret)
      outst_next = outst_reg + OUT_W'(1);
    else if (!issue_rd && ret)
      outst_next = outst_reg - OUT_W'(1);
  end

  // Entry storage carries no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_we[tail_ptr_reg]    <= write_extmem;
      fifo_addr[tail_ptr_reg]  <= addr_extmem;
      fifo_wdata[tail_ptr_reg] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
      outst_reg    <= '0;
      idle_reg     <= 1'b1;
      ovf_err_reg  <= 1'b0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
    end else begin
      if (push_ok)
        tail_ptr_reg <= tail_ptr_reg + PTR_W'(1);
      if (pop)
        head_ptr_reg <= head_ptr_reg + PTR_W'(1);
      if (request_extmem && !push_ok)
        ovf_err_reg <= 1'b1;
      count_reg  <= count_next;
      outst_reg  <= outst_next;
      idle_reg   <= (count_next == '0) && (outst_next == '0);
      if (issue_rd)
        rd_cnt_reg <= rd_cnt_reg + 32'd1;
      if (issue_wr)
        wr_cnt_reg <= wr_cnt_reg + 32'd1;
      valid_reg <= ret;
      if (ret)
        data_reg <= ret_zero ? '0 : mem_rdata;
    end
  end

`ifdef REGION_CHECK_EN
  localparam int unsigned KQ_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [ADDR_W-1:0] FMO_LO  = ADDR_W'(OFFSET_FMO);
  localparam logic [ADDR_W-1:0] FMO_HI  = ADDR_W'(OFFSET_KEX);
  localparam logic [ADDR_W-1:0] TOP_LIM = ADDR_W'(MEM_TOP);

  logic            fifo_kill [REQ_DEPTH];
  logic            kill_in;
  logic            kq_bits [MAX_OUTST];
  logic [KQ_W-1:0] kq_wr_ptr_reg, kq_rd_ptr_reg;
  logic            region_err_reg;

  assign kill_in = (addr_extmem >= TOP_LIM) ||
                   (write_extmem && ((addr_extmem < FMO_LO) || (addr_extmem >= FMO_HI)));
  assign head_kill = fifo_kill[head_ptr_reg];
  // Occupancy of the kill queue always equals outst, so no separate count is needed.
  assign ret_zero  = kq_bits[kq_rd_ptr_reg];
  assign region_err = region_err_reg;

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_kill[tail_ptr_reg] <= kill_in;
    if (issue_rd)
      kq_bits[kq_wr_ptr_reg] <= head_kill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kq_wr_ptr_reg  <= '0;
      kq_rd_ptr_reg  <= '0;
      region_err_reg <= 1'b0;
    end else begin
      if (issue_rd)
        kq_wr_ptr_reg <= (kq_wr_ptr_reg == KQ_W'(MAX_OUTST - 1)) ? '0 : kq_wr_ptr_reg + KQ_W'(1);
      if (ret)
        kq_rd_ptr_reg <= (kq_rd_ptr_reg == KQ_W'(MAX_OUTST - 1)) ? '0 : kq_rd_ptr_reg + KQ_W'(1);
      if (push_ok && kill_in)
        region_err_reg <= 1'b1;
    end
  end
`else
  logic unused_region_cfg;

  assign head_kill  = 1'b0;
  assign ret_zero   = 1'b0;
  assign region_err = 1'b0;
  assign unused_region_cfg = ^{OFFSET_FMO, OFFSET_KEX, MEM_TOP};
`endif

  assign valid_extmem = valid_reg;
  assign data_extmem  = data_reg;
  assign idle         = idle_reg;
  assign ovf_err      = ovf_err_reg;
  assign rd_cnt       = rd_cnt_reg;
  assign wr_cnt       = wr_cnt_reg;

endmodule
